cpu_core: RTL and testbench



---
 rtl/cpu_core.sv | 134 +++++++++++++
 tb/tb_cpu_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : cpu_core
// Purpose  : Single-cycle 8-bit processor core (CO224 simple processor).
//            Executes one 32-bit instruction per clock: PC register, PC+STEP
//            adder, control decode, 8x8-bit register file and 8-bit ALU.
//            Instruction memory is external and combinational, addressed by PC.
// Ports    : CLK          in   1   system clock, rising-edge active
//            RESET        in   1   synchronous active-high reset
//            PC           out  32  address of the current instruction
//            INSTRUCTION  in   32  instruction word fetched from PC
//            DBG_ADDR     in   3   debug read index   (CPU_DEBUG_PORT_EN only)
//            DBG_DATA     out  8   R[DBG_ADDR]        (CPU_DEBUG_PORT_EN only)
// Options  : define CPU_DEBUG_PORT_EN to add a third, combinational,
//            register-file read port for observation only.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] INSTRUCTION
`ifdef CPU_DEBUG_PORT_EN
  ,
  input  logic [2:0]  DBG_ADDR,
  output logic [7:0]  DBG_DATA
`endif
);

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Instruction fields
  logic [7:0] opcode;
  logic [2:0] dest_idx;
  logic [2:0] src1_idx;
  logic [2:0] src2_idx;
  logic [7:0] imm;

  assign opcode   = INSTRUCTION[31:24];
  assign dest_idx = INSTRUCTION[18:16];
  assign src1_idx = INSTRUCTION[10:8];
  assign src2_idx = INSTRUCTION[2:0];
  assign imm      = INSTRUCTION[7:0];

  // Upper bits of the register-index fields are architecturally ignored.
  logic unused_field_bits;
  assign unused_field_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  // State
  logic [31:0] pc_q, pc_d;
  logic [7:0]  rf_q [8];

  // Control decode
  logic       wr_en;
  logic       imm_sel;
  logic       neg_sel;
  logic [2:0] alu_sel;

  always_comb begin
    wr_en   = 1'b1;
    imm_sel = 1'b0;
    neg_sel = 1'b0;
    alu_sel = ALU_FWD;
    case (opcode)
      8'h00: imm_sel = 1'b1;                          // loadi
      8'h01: alu_sel = ALU_FWD;                       // mov
      8'h02: alu_sel = ALU_ADD;                       // add
      8'h03: begin alu_sel = ALU_ADD; neg_sel = 1'b1; end // sub
      8'h04: alu_sel = ALU_AND;                       // and
      8'h05: alu_sel = ALU_OR;                        // or
      default: wr_en = 1'b0;                          // NOP, PC still advances
    endcase
  end

  // Register-file read ports
  logic [7:0] rdata1;
  logic [7:0] rdata2;
  assign rdata1 = rf_q[src1_idx];
  assign rdata2 = rf_q[src2_idx];

`ifdef CPU_DEBUG_PORT_EN
  assign DBG_DATA = rf_q[DBG_ADDR];
`endif

  // Operand muxes: subtract is add of the two's complement of operand 2
  logic [7:0] neg_mux;
  logic [7:0] operand2;
  logic [7:0] alu_result;

  assign neg_mux  = neg_sel ? (~rdata2 + 8'd1) : rdata2;
  assign operand2 = imm_sel ? imm : neg_mux;

  always_comb begin
    alu_result = operand2;
    case (alu_sel)
      ALU_FWD: alu_result = operand2;
      ALU_ADD: alu_result = rdata1 + operand2;
      ALU_AND: alu_result = rdata1 & operand2;
      ALU_OR:  alu_result = rdata1 | operand2;
      default: alu_result = operand2;
    endcase
  end

  // PC update (wraps modulo 2^32)
  assign pc_d = pc_q + PC_STEP;
  assign PC   = pc_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Register file write port; reset discards the in-flight instruction
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      rf_q[dest_idx] <= alu_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_core
// Purpose  : Self-checking bench for cpu_core. A behavioural model of the
//            architectural state (PC and R0..R7) is stepped once per edge and
//            compared against the core every falling edge; directed program
//            fragments pin the model with literal values, followed by random
//            instruction streams with occasional resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_core;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] pc_a;
  logic [31:0] pc_b;
`ifdef CPU_DEBUG_PORT_EN
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data_a;
  logic [7:0]  dbg_data_b;
`endif

  cpu_core dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (pc_a),
    .INSTRUCTION (INSTRUCTION)
`ifdef CPU_DEBUG_PORT_EN
    ,
    .DBG_ADDR    (dbg_addr),
    .DBG_DATA    (dbg_data_a)
`endif
  );

  // Second instance only to observe PC wrap-around from a high reset vector
  cpu_core #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut_wrap (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (pc_b),
    .INSTRUCTION (INSTRUCTION)
`ifdef CPU_DEBUG_PORT_EN
    ,
    .DBG_ADDR    (dbg_addr),
    .DBG_DATA    (dbg_data_b)
`endif
  );

  initial CLK = 1'b0;
  always #4 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model of architectural state
  logic [7:0]  m_reg [8];
  logic [31:0] m_pc;
  logic [31:0] m_pc_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply the effect of one clock edge to the model
  task automatic model_edge(input logic rst, input logic [31:0] ins);
    int a, b, d;
    if (rst) begin
      m_pc      = 32'd0;
      m_pc_wrap = 32'hFFFF_FFF8;
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    end else begin
      a = int'(m_reg[ins[10:8]]);
      b = int'(m_reg[ins[2:0]]);
      d = int'(ins[18:16]);
      case (ins[31:24])
        8'h00: m_reg[d] = ins[7:0];
        8'h01: m_reg[d] = 8'(b);
        8'h02: m_reg[d] = 8'((a + b) % 256);
        8'h03: m_reg[d] = 8'((a - b + 256) % 256);
        8'h04: m_reg[d] = 8'(a & b);
        8'h05: m_reg[d] = 8'(a | b);
        default: ;
      endcase
      m_pc      = m_pc + 32'd4;
      m_pc_wrap = m_pc_wrap + 32'd4;
    end
  endtask

  // Drive one instruction, let one edge pass, update the model.
  // Inputs change 2 units after the edge, i.e. after PC has moved.
  task automatic step(input logic rst, input logic [31:0] ins);
    RESET       = rst;
    INSTRUCTION = ins;
`ifdef CPU_DEBUG_PORT_EN
    dbg_addr    = 3'($urandom_range(0, 7));
`endif
    @(posedge CLK);
    model_edge(rst, ins);
    #2;
  endtask

  // Compare process: full architectural state every falling edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("pc", pc_a, m_pc);
      check("pc_wrap", pc_b, m_pc_wrap);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("r%0d", i), {24'd0, dut.rf_q[i]}, {24'd0, m_reg[i]});
      end
`ifdef CPU_DEBUG_PORT_EN
      check("dbg_data", {24'd0, dbg_data_a}, {24'd0, m_reg[dbg_addr]});
`endif
    end
  end

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [2:0] d,
                                      input logic [2:0] s1, input logic [7:0] s2);
    return {op, 5'd0, d, 5'd0, s1, s2};
  endfunction

  task automatic run_prog_start();
    step(1'b0, 32'h0004_0005);   // loadi R4,5
    step(1'b0, 32'h0002_0009);   // loadi R2,9
    step(1'b0, 32'h0206_0402);   // add R6,R4,R2
  endtask

  initial begin
    logic [31:0] ins;
    logic [7:0]  op;
    logic [31:0] pc_before;
    RESET       = 1'b1;
    INSTRUCTION = 32'hFFFF_FFFF;
`ifdef CPU_DEBUG_PORT_EN
    dbg_addr    = 3'd0;
`endif

    // Reset held across edges
    step(1'b1, 32'h0004_0005);
    chk_en = 1'b1;
    step(1'b1, 32'h0004_0005);
    check("reset_pc", pc_a, 32'd0);
    check("reset_pc_wrap", pc_b, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), {24'd0, dut.rf_q[i]}, 32'd0);

    // loadi/loadi/add with PC stepping 4,8,12
    step(1'b0, 32'h0004_0005);
    check("pc_step1", pc_a, 32'd4);
    check("pc_wrap1", pc_b, 32'hFFFF_FFFC);
    step(1'b0, 32'h0002_0009);
    check("pc_step2", pc_a, 32'd8);
    check("pc_wrap2", pc_b, 32'h0000_0000);
    step(1'b0, 32'h0206_0402);
    check("pc_step3", pc_a, 32'd12);
    check("lit_r4", {24'd0, dut.rf_q[4]}, 32'h05);
    check("lit_r2", {24'd0, dut.rf_q[2]}, 32'h09);
    check("lit_r6", {24'd0, dut.rf_q[6]}, 32'h0E);

    // Subtract both ways, add wrap
    step(1'b0, enc(8'h03, 3'd1, 3'd2, 8'd4));
    check("lit_sub_pos", {24'd0, dut.rf_q[1]}, 32'h04);
    step(1'b0, enc(8'h03, 3'd1, 3'd4, 8'd2));
    check("lit_sub_neg", {24'd0, dut.rf_q[1]}, 32'hFC);
    step(1'b0, enc(8'h00, 3'd3, 3'd0, 8'hFF));
    step(1'b0, enc(8'h00, 3'd5, 3'd0, 8'h02));
    step(1'b0, enc(8'h02, 3'd7, 3'd3, 8'd5));
    check("lit_add_wrap", {24'd0, dut.rf_q[7]}, 32'h01);

    // and / or / mov
    step(1'b0, enc(8'h00, 3'd3, 3'd0, 8'hF0));
    step(1'b0, enc(8'h00, 3'd5, 3'd0, 8'h3C));
    step(1'b0, enc(8'h04, 3'd7, 3'd3, 8'd5));
    check("lit_and", {24'd0, dut.rf_q[7]}, 32'h30);
    step(1'b0, enc(8'h05, 3'd7, 3'd3, 8'd5));
    check("lit_or", {24'd0, dut.rf_q[7]}, 32'hFC);
    step(1'b0, enc(8'h01, 3'd0, 3'd0, 8'd3));
    check("lit_mov", {24'd0, dut.rf_q[0]}, 32'hF0);

    // Undefined opcode: no write, PC advances
    pc_before = m_pc;
    step(1'b0, 32'hFF06_0000);
    check("lit_nop_r6", {24'd0, dut.rf_q[6]}, 32'h0E);
    check("lit_nop_pc", pc_a, pc_before + 32'd4);

    // Mid-program reset discards the in-flight add, then re-run
    step(1'b1, enc(8'h02, 3'd6, 3'd6, 8'd6));
    check("lit_midrst_pc", pc_a, 32'd0);
    check("lit_midrst_r6", {24'd0, dut.rf_q[6]}, 32'h00);
    run_prog_start();
    check("lit_rerun_pc", pc_a, 32'd12);
    check("lit_rerun_r6", {24'd0, dut.rf_q[6]}, 32'h0E);

    // Random instruction stream with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(0, 255));
      else                           op = 8'($urandom_range(0, 6));
      ins = {op, 24'($urandom)};
      step(($urandom_range(0, 39) == 0), ins);
    end

    step(1'b0, 32'hFF00_0000);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
